// File: rtl/run_initiator.sv
// run_initiator: launches batches of core runs over the req/done handshake.
// Holds the core in reset, issues a one-cycle req, times the run and
// reports its cycle count. A watchdog aborts the batch when done is late.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | core held in reset, waiting for start
// RST    | core held in reset for RST_CYC cycles before the next launch
// REQ    | core released, one-cycle req pulse
// WAIT   | counting cycles until done, or aborting at TIMEOUT
module run_initiator #(
    parameter int NUM_RUNS = 3,
    parameter int RUN_W    = 2,
    parameter int CNT_W    = 16,
    parameter int RST_CYC  = 2,
    parameter int TIMEOUT  = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             done,
    output logic             req,
    output logic             core_reset,
    output logic             busy,
    output logic [RUN_W-1:0] run_idx,
    output logic [CNT_W-1:0] cycles,
    output logic             cycles_valid,
    output logic             batch_done,
    output logic             timeout_err
);

    localparam int RC_W = (RST_CYC < 2) ? 1 : $clog2(RST_CYC + 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] IDX_LAST = RUN_W'(NUM_RUNS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        REQ  = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [RC_W-1:0]  r_rst_cnt;
    logic [RC_W-1:0]  w_rst_cnt_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [RUN_W-1:0] r_run_idx;
    logic [RUN_W-1:0] w_run_idx_nxt;
    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] w_cycles_nxt;
    logic             r_cycles_valid;
    logic             w_cycles_valid_nxt;
    logic             r_batch_done;
    logic             w_batch_done_nxt;
    logic             r_timeout_err;
    logic             w_timeout_err_nxt;
    logic             r_req;
    logic             r_core_reset;
    logic             r_busy;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update decisions
    always_comb begin
        w_state_nxt        = r_state;
        w_rst_cnt_nxt      = r_rst_cnt;
        w_cnt_nxt          = r_cnt;
        w_run_idx_nxt      = r_run_idx;
        w_cycles_nxt       = r_cycles;
        w_cycles_valid_nxt = 1'b0;
        w_batch_done_nxt   = 1'b0;
        w_timeout_err_nxt  = r_timeout_err;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt       = RST;
                    w_run_idx_nxt     = '0;
                    w_timeout_err_nxt = 1'b0;
                    w_rst_cnt_nxt     = RC_W'(1);
                end
            end

            RST: begin
                // run_idx keeps the finished run's index through the
                // cycles_valid cycle and advances right after it.
                if (r_cycles_valid) begin
                    w_run_idx_nxt = r_run_idx + RUN_W'(1);
                end
                if (r_rst_cnt == RC_LAST) begin
                    w_state_nxt = REQ;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + RC_W'(1);
                end
            end

            REQ: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = CNT_W'(1);
            end

            WAIT: begin
                if (done) begin
                    w_cycles_nxt       = r_cnt;
                    w_cycles_valid_nxt = 1'b1;
                    if (r_run_idx == IDX_LAST) begin
                        w_batch_done_nxt = 1'b1;
                        w_state_nxt      = IDLE;
                    end else begin
                        w_state_nxt   = RST;
                        w_rst_cnt_nxt = RC_W'(1);
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout_err_nxt = 1'b1;
                    w_batch_done_nxt  = 1'b1;
                    w_state_nxt       = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Counters, run bookkeeping and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_cnt      <= '0;
            r_cnt          <= '0;
            r_run_idx      <= '0;
            r_cycles       <= '0;
            r_cycles_valid <= 1'b0;
            r_batch_done   <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_rst_cnt      <= w_rst_cnt_nxt;
            r_cnt          <= w_cnt_nxt;
            r_run_idx      <= w_run_idx_nxt;
            r_cycles       <= w_cycles_nxt;
            r_cycles_valid <= w_cycles_valid_nxt;
            r_batch_done   <= w_batch_done_nxt;
            r_timeout_err  <= w_timeout_err_nxt;
        end
    end

    // State-decoded outputs, registered from the next state so they
    // line up with the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req        <= 1'b0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_req        <= (w_state_nxt == REQ);
            r_core_reset <= (w_state_nxt == IDLE) || (w_state_nxt == RST);
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    assign req          = r_req;
    assign core_reset   = r_core_reset;
    assign busy         = r_busy;
    assign run_idx      = r_run_idx;
    assign cycles       = r_cycles;
    assign cycles_valid = r_cycles_valid;
    assign batch_done   = r_batch_done;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_run_initiator.sv
// Bench for run_initiator: a core model answers each req with done after a
// chosen number of WAIT cycles; expected (run_idx, cycles) results are
// queued when done is driven and compared on every cycles_valid pulse.
module tb_run_initiator;

    localparam int NUM_RUNS = 3;
    localparam int RUN_W    = 2;
    localparam int CNT_W    = 8;
    localparam int RST_CYC  = 2;
    localparam int TIMEOUT  = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             done = 1'b0;
    logic             req;
    logic             core_reset;
    logic             busy;
    logic [RUN_W-1:0] run_idx;
    logic [CNT_W-1:0] cycles;
    logic             cycles_valid;
    logic             batch_done;
    logic             timeout_err;

    run_initiator #(
        .NUM_RUNS (NUM_RUNS),
        .RUN_W    (RUN_W),
        .CNT_W    (CNT_W),
        .RST_CYC  (RST_CYC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .done         (done),
        .req          (req),
        .core_reset   (core_reset),
        .busy         (busy),
        .run_idx      (run_idx),
        .cycles       (cycles),
        .cycles_valid (cycles_valid),
        .batch_done   (batch_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int cyc;
        int last;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_vec  = 0;
    int n_miss = 0;
    int n_cv   = 0;
    int n_req  = 0;
    int n_bd   = 0;
    logic h1 = 1'b0;
    logic h2 = 1'b0;
    logic prev_req = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard compare, req framing, batch_done framing
    always @(negedge clk) begin
        if (cycles_valid) begin
            check("cv_expected", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("cv_run_idx", int'(run_idx), mon_e.idx);
                check("cv_cycles", int'(cycles), mon_e.cyc);
                check("cv_batch_done", int'(batch_done), mon_e.last);
            end
            n_cv++;
        end
        if (req) begin
            n_req++;
            check("req_core_reset_lo", int'(core_reset), 0);
            check("core_reset_before_req", int'({h2, h1}), 3);
            check("req_single_cycle", int'(prev_req), 0);
        end
        if (batch_done) begin
            n_bd++;
            check("busy_at_batch_done", int'(busy), 0);
        end
        prev_req = req;
        h2 = h1;
        h1 = core_reset;
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_core_reset"}, int'(core_reset), 1);
        check({tag, "_req"}, int'(req), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_run_idx"}, int'(run_idx), 0);
        check({tag, "_cycles"}, int'(cycles), 0);
        check({tag, "_cycles_valid"}, int'(cycles_valid), 0);
        check({tag, "_batch_done"}, int'(batch_done), 0);
        check({tag, "_timeout_err"}, int'(timeout_err), 0);
    endtask

    task automatic start_batch(input int te_before);
        @(posedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        check("te_before_start", int'(timeout_err), te_before);
        check("idle_busy", int'(busy), 0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("start_busy", int'(busy), 1);
        check("start_te_clear", int'(timeout_err), 0);
        check("start_run_idx", int'(run_idx), 0);
        check("start_core_reset", int'(core_reset), 1);
    endtask

    task automatic wait_req();
        int seen;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req) begin
                seen = 1;
                break;
            end
        end
        check("req_seen", seen, 1);
    endtask

    task automatic wait_bd(output int lat);
        int seen;
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (batch_done) begin
                seen = 1;
                lat  = i;
                break;
            end
        end
        check("batch_done_seen", seen, 1);
    endtask

    // One run of the core model: done high during WAIT cycle k.
    // poke pulses start in WAIT cycle 1 (needs k >= 3).
    task automatic do_run(input int idx, input int k, input int poke);
        exp_t e;
        wait_req();
        done = 1'b0;
        e.idx  = idx;
        e.cyc  = k;
        e.last = (idx == NUM_RUNS - 1) ? 1 : 0;
        sb_q.push_back(e);
        for (int c = 1; c <= k; c++) begin
            @(posedge clk);
            #1;
            if (poke != 0 && c == 1) start = 1'b1;
            if (poke != 0 && c == 2) begin
                start = 1'b0;
                check("poke_run_idx", int'(run_idx), idx);
                check("poke_busy", int'(busy), 1);
            end
        end
        done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
    endtask

    task automatic batch_end(input string tag, input int cv0, input int req0,
                             input int bd0, input int exp_cv, input int exp_req,
                             input int exp_idx, input int exp_cyc, input int exp_te);
        int lat;
        wait_bd(lat);
        #2;
        check({tag, "_cv_count"}, n_cv - cv0, exp_cv);
        check({tag, "_req_count"}, n_req - req0, exp_req);
        check({tag, "_bd_count"}, n_bd - bd0, 1);
        check({tag, "_run_idx"}, int'(run_idx), exp_idx);
        check({tag, "_cycles"}, int'(cycles), exp_cyc);
        check({tag, "_timeout_err"}, int'(timeout_err), exp_te);
        check({tag, "_sb_drained"}, sb_q.size(), 0);
    endtask

    initial begin
        int cv0, req0, bd0, lat;

        // Reset values while reset is held low
        @(negedge clk);
        check_reset_values("por");
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Reset asserted during WAIT of run 1
        start_batch(0);
        do_run(0, 5, 0);
        wait_req();
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_reset_values("midrst");
        check("midrst_sb_drained", sb_q.size(), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Nominal batch after reset: done at WAIT cycles 5, 7, 3
        cv0 = n_cv; req0 = n_req; bd0 = n_bd;
        start_batch(0);
        do_run(0, 5, 0);
        do_run(1, 7, 0);
        do_run(2, 3, 0);
        batch_end("nominal", cv0, req0, bd0, 3, 3, 2, 3, 0);

        // Core never answers run 1: watchdog abort after 20 WAIT cycles
        cv0 = n_cv; req0 = n_req; bd0 = n_bd;
        start_batch(0);
        do_run(0, 2, 0);
        wait_req();
        wait_bd(lat);
        check("timeout_latency", lat, TIMEOUT + 1);
        #2;
        check("timeout_cv_count", n_cv - cv0, 1);
        check("timeout_req_count", n_req - req0, 2);
        check("timeout_bd_count", n_bd - bd0, 1);
        check("timeout_run_idx", int'(run_idx), 1);
        check("timeout_cycles", int'(cycles), 2);
        check("timeout_err_set", int'(timeout_err), 1);
        check("timeout_busy", int'(busy), 0);

        // done exactly at WAIT cycle TIMEOUT still succeeds; start also
        // clears the sticky error left by the aborted batch
        cv0 = n_cv; req0 = n_req; bd0 = n_bd;
        start_batch(1);
        do_run(0, TIMEOUT, 0);
        do_run(1, 1, 0);
        do_run(2, 2, 0);
        batch_end("edge", cv0, req0, bd0, 3, 3, 2, 2, 0);

        // done held through IDLE/RST/REQ, then low, then high at cycle 4;
        // start pulsed during run 1 must not disturb the batch
        cv0 = n_cv; req0 = n_req; bd0 = n_bd;
        done = 1'b1;
        start_batch(0);
        do_run(0, 4, 0);
        do_run(1, 6, 1);
        do_run(2, 2, 0);
        batch_end("held", cv0, req0, bd0, 3, 3, 2, 2, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global guard so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d vectors, expected completion", n_vec);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/run_initiator.md
# run_initiator

Initiator side of the `req`/`done` run handshake used by `top_level`: holds the core in reset, launches a program run with a one-cycle `req` pulse and waits for `done`. It repeats this for `NUM_RUNS` back-to-back runs per batch and reports the cycle count of each run. A watchdog aborts the batch if `done` does not arrive in time. It replaces bench-driven stimulus so batches of runs can be launched from hardware.

## Interface
- `NUM_RUNS`, 3: runs per batch, 1..2^`RUN_W`
- `RUN_W`, 2: width of `run_idx`
- `CNT_W`, 16: width of the cycle counter
- `RST_CYC`, 2: cycles `core_reset` is held high before each `req`, at least 1
- `TIMEOUT`, 1000: maximum `WAIT` cycles per run, 1..2^`CNT_W`-1
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a batch; sampled only in `IDLE`
- `done`  in  1  run complete, from core; level, sampled only in `WAIT`
- `req`  out  1  one-cycle launch pulse to core
- `core_reset`  out  1  active-high reset to core
- `busy`  out  1  high in every state except `IDLE`
- `run_idx`  out  `RUN_W`  index of the current or last run
- `cycles`  out  `CNT_W`  cycle count of the last successful run
- `cycles_valid`  out  1  one-cycle pulse; `cycles` and `run_idx` are valid
- `batch_done`  out  1  one-cycle pulse at batch end (success or abort)
- `timeout_err`  out  1  sticky; set on abort, cleared by the next accepted `start`

## Operation
- States: `IDLE`, `RST`, `REQ`, `WAIT`.
- `IDLE`:
  - `core_reset`=1, `req`=0.
  - `start`=1 → `RST`; `run_idx`←0, `timeout_err`←0, reset counter←1.
- `RST`:
  - `core_reset`=1; runs for `RST_CYC` cycles, then → `REQ`.
  - `done` is ignored.
- `REQ`:
  - `core_reset`=0, `req`=1 for exactly this one cycle, then → `WAIT`; wait counter `cnt`←1.
  - `done` is ignored.
- `WAIT`:
  - `core_reset`=0, `req`=0. Priority each cycle:
  - (1) `done`=1: success. `cycles`←`cnt`; `cycles_valid` pulses next cycle with the current `run_idx`.
    - If `run_idx`=`NUM_RUNS`-1: `batch_done` pulses on that same next cycle, → `IDLE`.
    - Otherwise `run_idx`+1 on that same next cycle, → `RST`.
  - (2) `cnt`=`TIMEOUT`: abort. `timeout_err`←1, `batch_done` pulses next cycle, no `cycles_valid`, `run_idx` holds the failing index, → `IDLE`.
  - (3) otherwise `cnt`+1.
- `done` and timeout in the same cycle: `done` wins, so the maximum successful count is `TIMEOUT`.
- `start` while `busy` is ignored. `start` held high in `IDLE` starts a new batch immediately after `batch_done`.
- `cycles` holds its value across runs and batches until the next success overwrites it.

## Timing
- Reset values (async, immediate while `reset`=0):
  - state=`IDLE`, `core_reset`=1
  - `req`=0, `busy`=0, `run_idx`=0, `cycles`=0
  - `cycles_valid`=0, `batch_done`=0, `timeout_err`=0
- Reset mid-batch aborts with no `batch_done`; all outputs take reset values; `core_reset` returns to 1.
- All outputs are registered; no combinational input-to-output paths.
- Per run, with `start` sampled at edge E:
  - `core_reset` high through cycles E+1..E+`RST_CYC`.
  - `req` high in cycle E+`RST_CYC`+1.
  - `WAIT` begins the cycle after that with `cnt`=1.
  - `done` seen in `WAIT` cycle k → `cycles`=k, `cycles_valid` in cycle k+1.
- Run-to-run gap: the next run's `RST` begins in the `cycles_valid` cycle; the next `req` follows `RST_CYC` cycles later.
- `busy` rises the cycle after `start` is accepted and falls in the `batch_done` cycle.

## Test plan
Parameters for all cases: `NUM_RUNS`=3, `RST_CYC`=2, `TIMEOUT`=20, `CNT_W`=8.
- Reset during `WAIT` of run 1 → all outputs at reset values immediately. A later `start` runs a full batch from `run_idx`=0.
- Nominal batch, core asserts `done` in `WAIT` cycles 5, 7, 3 →
  - three `cycles_valid` pulses with (`run_idx`,`cycles`) = (0,5), (1,7), (2,3);
  - `batch_done` coincides with the third pulse;
  - exactly 3 `req` pulses, each preceded by 2 `core_reset` cycles.
- Core never asserts `done` on run 1 → after 20 `WAIT` cycles `timeout_err`=1, `batch_done` pulse, `run_idx`=1, only one `cycles_valid` (run 0).
- `done` first high on `WAIT` cycle 20 → counts as success with `cycles`=20, `timeout_err` stays 0.
- `done` held high during `RST`/`REQ`, then low, then high at `WAIT` cycle 4 → `cycles`=4. `start` pulsed mid-batch → no effect on state or `run_idx`.
- `timeout_err` set by an aborted batch, then `start` → `timeout_err` clears the cycle after `start` is accepted.
